// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: instruction fetch front end with a DEPTH-entry {pc, instruction} prefetch FIFO
//   clk, rst (async, active-low)
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata : instruction memory, one request in flight
//   redirect_valid/redirect_pc                         : flush and restart fetch
//   inst_valid/inst_data/inst_pc/inst_ready            : downstream valid/ready stream
//   Optional: define IFETCH_BYPASS_EN to forward a response to an empty FIFO's output in the same cycle.
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;
  state_t state, state_nxt;
  logic [31:0] fetch_pc, resp_pc;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic has_head, gnt_fire, resp, bypass, push, pop;
  assign has_head = count != '0;
  assign imem_req = rst && state == FETCH && count < (AW+1)'(DEPTH);
  assign imem_addr = fetch_pc;
  assign gnt_fire = imem_req && imem_gnt;
  assign resp = state == WAIT && imem_rvalid;
  // fetch_pc advanced on the grant and only changes again on a redirect, which drops the response
  assign resp_pc = fetch_pc - 32'd4;
`ifdef IFETCH_BYPASS_EN
  assign bypass = !has_head && resp && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif
  assign inst_valid = has_head || bypass;
  assign inst_data = has_head ? data_q[rd_ptr] : bypass ? imem_rdata : '0;
  assign inst_pc = has_head ? pc_q[rd_ptr] : bypass ? resp_pc : '0;
  assign pop = has_head && inst_ready;
  assign push = resp && !redirect_valid && !(bypass && inst_ready);
  // a redirect must still absorb a response that is in flight, hence DISCARD
  always_comb begin
    state_nxt = redirect_valid ? ((gnt_fire || (state != FETCH && !imem_rvalid)) ? DISCARD : FETCH)
              : gnt_fire ? WAIT
              : (state != FETCH && imem_rvalid) ? FETCH
              : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      fetch_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      fetch_pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : gnt_fire ? fetch_pc + 32'd4 : fetch_pc;
      wr_ptr <= redirect_valid ? '0 : wr_ptr + AW'(push);
      rd_ptr <= redirect_valid ? '0 : rd_ptr + AW'(pop);
      count <= redirect_valid ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr] <= resp_pc;
    end
  end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: segment table plus scoreboard for ifetch_prefetch
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst, imem_req, imem_gnt, imem_rvalid, redirect_valid, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_data, inst_pc;
  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } inst_t;
  typedef struct {
    bit          pre_rst;
    int          cycles;
    int          lat;
    bit          gnt;
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          exp_req;
    logic [31:0] exp_addr;
    int          exp_grants;
  } seg_t;
  inst_t sb[$];
  seg_t tbl[13];
  int checks = 0, errors = 0;
  int cyc = 0, lat = 1, due = 0, grants = 0;
  bit pend = 1'b0, stale = 1'b0;
  logic [31:0] pend_addr = '0, exp_addr = RESET_PC;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    pend = 1'b0;
    stale = 1'b0;
    exp_addr = RESET_PC;
  endtask
  task automatic tick(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit rv, byp, has;
    inst_t head;
    @(negedge clk);
    rv = pend && cyc == due;
    imem_gnt = gnt;
    inst_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_rvalid = rv;
    imem_rdata = rv ? mem(pend_addr) : $urandom;
    #1;
    has = sb.size() != 0;
    byp = 1'b0;
`ifdef IFETCH_BYPASS_EN
    byp = !has && rv && !stale && !redir;
`endif
    if (sb.size() == DEPTH) chk("req_when_full", 32'(imem_req), 32'd0);
    chk("inst_valid", 32'(inst_valid), 32'(has || byp));
    if (has || byp) begin
      if (has) head = sb[0];
      else begin
        head.pc = pend_addr;
        head.data = mem(pend_addr);
      end
      chk("inst_pc", inst_pc, head.pc);
      chk("inst_data", inst_data, head.data);
      if (rdy && has) void'(sb.pop_front());
    end
    if (rv) begin
      if (!stale && !redir && !(byp && rdy)) begin
        head.pc = pend_addr;
        head.data = mem(pend_addr);
        sb.push_back(head);
      end
      pend = 1'b0;
      stale = 1'b0;
    end
    if (imem_req && gnt) begin
      chk("one_outstanding", 32'(pend), 32'd0);
      chk("imem_addr", imem_addr, exp_addr);
      pend = 1'b1;
      pend_addr = exp_addr;
      due = cyc + lat;
      exp_addr += 32'd4;
      grants++;
    end
    if (redir) begin
      sb.delete();
      exp_addr = {rpc[31:2], 2'b00};
      stale = pend;
    end
    cyc++;
  endtask
  initial begin
    int g0;
    rst = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    inst_ready = 1'b0;
    tbl[0]  = '{0, 5,  1, 1, 1, 0, 32'h0,   1, 32'h8,   3};
    tbl[1]  = '{0, 12, 1, 1, 0, 0, 32'h0,   0, 32'h18,  3};
    tbl[2]  = '{0, 1,  1, 1, 1, 0, 32'h0,   0, 32'h18,  0};
    tbl[3]  = '{0, 3,  1, 1, 0, 0, 32'h0,   0, 32'h1C,  1};
    tbl[4]  = '{0, 4,  1, 1, 1, 0, 32'h0,   1, 32'h20,  2};
    tbl[5]  = '{0, 1,  1, 1, 1, 1, 32'h100, 0, 32'h24,  0};
    tbl[6]  = '{0, 6,  3, 1, 1, 0, 32'h0,   0, 32'h108, 2};
    tbl[7]  = '{0, 1,  3, 1, 1, 1, 32'h200, 0, 32'h108, 0};
    tbl[8]  = '{0, 4,  3, 1, 1, 0, 32'h0,   0, 32'h204, 1};
    tbl[9]  = '{0, 1,  1, 1, 1, 0, 32'h0,   0, 32'h204, 0};
    tbl[10] = '{0, 1,  1, 1, 1, 1, 32'h203, 1, 32'h204, 1};
    tbl[11] = '{0, 3,  2, 1, 1, 0, 32'h0,   0, 32'h204, 1};
    tbl[12] = '{1, 3,  1, 1, 1, 0, 32'h0,   1, 32'h4,   2};
    do_reset();
    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      lat = tbl[i].lat;
      g0 = grants;
      for (int k = 0; k < tbl[i].cycles; k++)
        tick(tbl[i].gnt, tbl[i].ready, tbl[i].redir && k == 0, tbl[i].rpc);
      chk($sformatf("seg%0d_imem_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("seg%0d_imem_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("seg%0d_grants", i), 32'(grants - g0), 32'(tbl[i].exp_grants));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
